// File: rtl/p66b_pkg.sv
// Constants and helpers shared by the 66b receive descrambler, transmit scrambler and 66b decoder.
// Self-synchronous x^58+x^39+1 scrambling; BER monitor defaults match a 125 us window at 156.25 Mblock/s.
package p66b_pkg;

  localparam logic [1:0] SYNC_DATA = 2'b01;
  localparam logic [1:0] SYNC_CTRL = 2'b10;

  localparam int SCR_TAP_A = 39;
  localparam int SCR_TAP_B = 58;
  localparam int SCR_LEN   = 58;

  localparam int BER_WINDOW_DEF = 19531;
  localparam int BER_LIMIT_DEF  = 16;
  localparam int BER_CW_DEF     = 15;
  localparam int BER_CNT_W      = 6;

  typedef enum logic [1:0] {
    HDR_BAD_00 = 2'b00,
    HDR_DATA   = 2'b01,
    HDR_CTRL   = 2'b10,
    HDR_BAD_11 = 2'b11
  } sync_hdr_e;

  typedef struct packed {
    logic [63:0] payload;
    logic [1:0]  hdr;
  } blk_t;

  function automatic logic hdr_is_bad(input logic [1:0] hdr);
    return !((hdr == SYNC_DATA) || (hdr == SYNC_CTRL));
  endfunction

  // x = {payload, history}; each output bit xors the wire bit with the bits 39 and 58 positions earlier.
  function automatic logic [63:0] descramble(input logic [63:0] p, input logic [SCR_LEN-1:0] h);
    logic [SCR_LEN+63:0] x;
    x = {p, h};
    return x[SCR_LEN +: 64] ^ x[(SCR_LEN - SCR_TAP_A) +: 64] ^ x[(SCR_LEN - SCR_TAP_B) +: 64];
  endfunction

endpackage

// File: rtl/p66b_rxdescrambler_if.sv
// Block stream into the descrambler and descrambled block stream plus header/BER status out.
// No backpressure: the producer (gearbox/aligner) drives S_VALID whenever a block is aligned.
interface p66b_rxdescrambler_if;
  logic        S_VALID;
  logic [65:0] S_DATA;
  logic        M_VALID;
  logic [65:0] M_DATA;
  logic        o_hdr_err;
  logic        o_hi_ber;
  logic [5:0]  o_ber_count;

  modport master (
    output S_VALID, S_DATA,
    input  M_VALID, M_DATA, o_hdr_err, o_hi_ber, o_ber_count
  );

  modport slave (
    input  S_VALID, S_DATA,
    output M_VALID, M_DATA, o_hdr_err, o_hi_ber, o_ber_count
  );
endinterface

// File: rtl/p66b_hiber_monitor.sv
// Counts invalid sync headers per BER_WINDOW valid beats and flags high BER (built only with P66B_HIBER_EN).
// Outputs are registered one clock after the beat; no backpressure, idle cycles leave state untouched.
`ifdef P66B_HIBER_EN
module p66b_hiber_monitor
  import p66b_pkg::*;
#(
  parameter int BER_WINDOW = BER_WINDOW_DEF,
  parameter int BER_LIMIT  = BER_LIMIT_DEF,
  parameter int CW         = BER_CW_DEF
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_valid,
  input  logic                 i_bad,
  output logic                 o_hi_ber,
  output logic [BER_CNT_W-1:0] o_ber_count
);

  localparam logic [CW-1:0]        WIN_LAST = CW'(BER_WINDOW - 1);
  localparam logic [BER_CNT_W:0]   LIMIT    = (BER_CNT_W + 1)'(BER_LIMIT);

  logic [CW-1:0]        win_cnt;
  logic                 win_end;
  logic [BER_CNT_W:0]   cnt_total;
  logic [BER_CNT_W-1:0] cnt_sat;

  assign win_end = (win_cnt == WIN_LAST);
  // One extra bit so a bad header on top of a saturated count is still seen at the window end.
  assign cnt_total = {1'b0, o_ber_count} + {{BER_CNT_W{1'b0}}, i_bad};
  assign cnt_sat   = cnt_total[BER_CNT_W] ? {BER_CNT_W{1'b1}} : cnt_total[BER_CNT_W-1:0];

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      win_cnt     <= '0;
      o_ber_count <= '0;
      o_hi_ber    <= 1'b0;
    end else if (i_valid) begin
      if (win_end) begin
        win_cnt     <= '0;
        o_ber_count <= '0;
        o_hi_ber    <= (cnt_total >= LIMIT);
      end else begin
        win_cnt     <= win_cnt + CW'(1);
        o_ber_count <= cnt_sat;
        if ({1'b0, cnt_sat} >= LIMIT) begin
          o_hi_ber <= 1'b1;
        end
      end
    end
  end

endmodule
`endif

// File: rtl/p66b_rxdescrambler.sv
// Self-synchronous 64b payload descrambler with sync-header check; 1-clock latency, no backpressure.
// BER monitor present only when P66B_HIBER_EN is defined, otherwise o_hi_ber/o_ber_count read 0.
module p66b_rxdescrambler
  import p66b_pkg::*;
#(
  parameter int BER_WINDOW = BER_WINDOW_DEF,
  parameter int BER_LIMIT  = BER_LIMIT_DEF,
  parameter int CW         = BER_CW_DEF
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  p66b_rxdescrambler_if.slave  bus
);

  logic [SCR_LEN-1:0] hist;
  logic               hdr_bad;
  blk_t               out_blk;

  assign hdr_bad         = hdr_is_bad(bus.S_DATA[1:0]);
  assign out_blk.payload = descramble(bus.S_DATA[65:2], hist);
  assign out_blk.hdr     = bus.S_DATA[1:0];

  // History tracks scrambled wire bits, so bad-header blocks still feed it.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      hist          <= '0;
      bus.M_VALID   <= 1'b0;
      bus.M_DATA    <= '0;
      bus.o_hdr_err <= 1'b0;
    end else begin
      bus.M_VALID <= bus.S_VALID;
      if (bus.S_VALID) begin
        hist          <= bus.S_DATA[65 -: SCR_LEN];
        bus.M_DATA    <= out_blk;
        bus.o_hdr_err <= hdr_bad;
      end
    end
  end

`ifdef P66B_HIBER_EN
  logic                 hi_ber;
  logic [BER_CNT_W-1:0] ber_count;

  p66b_hiber_monitor #(
    .BER_WINDOW (BER_WINDOW),
    .BER_LIMIT  (BER_LIMIT),
    .CW         (CW)
  ) u_hiber (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_valid     (bus.S_VALID),
    .i_bad       (hdr_bad),
    .o_hi_ber    (hi_ber),
    .o_ber_count (ber_count)
  );

  assign bus.o_hi_ber    = hi_ber;
  assign bus.o_ber_count = ber_count;
`else
  assign bus.o_hi_ber    = 1'b0;
  assign bus.o_ber_count = '0;
`endif

endmodule

// File: tb/tb_p66b_rxdescrambler.sv
// Directed + randomized bench: bit-serial reference descrambler and per-window BER model.
module tb_p66b_rxdescrambler;

  localparam int WIN = 100;
  localparam int LIM = 16;
  localparam int CWT = 7;
`ifdef P66B_HIBER_EN
  localparam bit HB = 1'b1;
`else
  localparam bit HB = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  p66b_rxdescrambler_if bus ();

  p66b_rxdescrambler #(
    .BER_WINDOW (WIN),
    .BER_LIMIT  (LIM),
    .CW         (CWT)
  ) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference state: last 58 received wire bits (oldest first) and expected outputs.
  bit          rxq[$];
  bit          txq[$];
  logic        e_mv;
  logic [65:0] e_md;
  logic        e_err;
  logic        e_hi;
  int          e_cnt;
  int          e_win;

  task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    rxq.delete();
    repeat (58) rxq.push_back(1'b0);
    e_mv  = 1'b0;
    e_md  = '0;
    e_err = 1'b0;
    e_hi  = 1'b0;
    e_cnt = 0;
    e_win = 0;
  endtask

  task automatic model_beat(input logic [65:0] d);
    logic [63:0] o;
    bit          s;
    bit          bad;
    for (int j = 0; j < 64; j++) begin
      s    = d[2+j];
      o[j] = s ^ rxq[58-39] ^ rxq[58-58];
      rxq.push_back(s);
      void'(rxq.pop_front());
    end
    bad   = (d[1:0] == 2'b00) || (d[1:0] == 2'b11);
    e_md  = {o, d[1:0]};
    e_err = bad;
    if (HB) begin
      if (e_win == WIN - 1) begin
        e_hi  = ((e_cnt + int'(bad)) >= LIM);
        e_cnt = 0;
        e_win = 0;
      end else begin
        e_win++;
        if (bad && e_cnt < 63) e_cnt++;
        if (e_cnt >= LIM) e_hi = 1'b1;
      end
    end
  endtask

  task automatic step(input logic r, input logic v, input logic [65:0] d);
    rst         = r;
    bus.S_VALID = v;
    bus.S_DATA  = d;
    @(posedge clk);
    if (r) model_reset();
    else begin
      e_mv = v;
      if (v) model_beat(d);
    end
    #1;
    chk("m_valid",   66'(bus.M_VALID),     66'(e_mv));
    chk("m_data",    bus.M_DATA,           e_md);
    chk("hdr_err",   66'(bus.o_hdr_err),   66'(e_err));
    chk("hi_ber",    66'(bus.o_hi_ber),    66'(e_hi));
    chk("ber_count", 66'(bus.o_ber_count), 66'(e_cnt[5:0]));
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // One valid block followed by an idle clock carrying junk that must be ignored.
  task automatic beat(input logic [1:0] h);
    step(1'b0, 1'b1, {rnd64(), h});
    step(1'b0, 1'b0, {rnd64(), 2'($urandom)});
  endtask

  initial begin
    logic [63:0] d64;
    logic [63:0] sp;
    logic [1:0]  h;
    bit          s;

    model_reset();
    rst         = 1'b1;
    bus.S_VALID = 1'b0;
    bus.S_DATA  = '0;

    // Reset state
    step(1'b1, 1'b0, '0);
    step(1'b1, 1'b1, {rnd64(), 2'b01});
    chk("rst_m_data", bus.M_DATA, 66'h0);

    // Impulse response
    step(1'b0, 1'b1, {64'h1, 2'b01});
    chk("impulse1", bus.M_DATA, {64'h0400_0080_0000_0001, 2'b01});
    step(1'b0, 1'b1, {64'h0, 2'b10});
    chk("impulse2", bus.M_DATA, {64'h0, 2'b10});
    step(1'b0, 1'b0, {rnd64(), 2'b11});
    chk("hold_data", bus.M_DATA, {64'h0, 2'b10});

    // Round trip through a bench scrambler with random starting state
    step(1'b1, 1'b0, '0);
    txq.delete();
    repeat (58) txq.push_back(1'($urandom));
    for (int n = 0; n < 1000; n++) begin
      d64 = rnd64();
      h   = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
      for (int j = 0; j < 64; j++) begin
        s     = d64[j] ^ txq[58-39] ^ txq[58-58];
        sp[j] = s;
        txq.push_back(s);
        void'(txq.pop_front());
      end
      step(1'b0, 1'b1, {sp, h});
      if (n >= 1) chk("rt_payload", 66'(bus.M_DATA[65:2]), 66'(d64));
      chk("rt_hdr", 66'(bus.M_DATA[1:0]), 66'(h));
      if ($urandom_range(0, 1) == 1) step(1'b0, 1'b0, {rnd64(), 2'($urandom)});
    end

    // Random mix of good and bad headers
    step(1'b1, 1'b0, '0);
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 5))
        0:       h = 2'b00;
        1:       h = 2'b11;
        2, 3:    h = 2'b10;
        default: h = 2'b01;
      endcase
      beat(h);
    end

    // Saturation of the error count
    step(1'b1, 1'b0, '0);
    for (int n = 0; n < 70; n++) beat((n % 2 == 0) ? 2'b00 : 2'b11);
    chk("sat_count", 66'(bus.o_ber_count), HB ? 66'd63 : 66'd0);
    chk("sat_hi", 66'(bus.o_hi_ber), 66'(HB));

    // hi_ber set inside a window, held over the boundary, cleared by a clean window
    step(1'b1, 1'b0, '0);
    for (int b = 0; b < 210; b++) begin
      beat((b >= 10 && b <= 25) ? 2'b00 : 2'b01);
      if (b == 24) chk("hb_before", 66'(bus.o_hi_ber), 66'd0);
      if (b == 25) chk("hb_rise",   66'(bus.o_hi_ber), 66'(HB));
      if (b == 99) chk("hb_hold",   66'(bus.o_hi_ber), 66'(HB));
      if (b == 99) chk("hb_wrap",   66'(bus.o_ber_count), 66'd0);
      if (b == 199) chk("hb_clear", 66'(bus.o_hi_ber), 66'd0);
    end

    // Boundary: 15 errors mid-window plus one on the final beat
    step(1'b1, 1'b0, '0);
    for (int b = 0; b < 102; b++) begin
      beat(((b >= 50 && b <= 64) || b == 99 || b == 101) ? 2'b11 : 2'b10);
      if (b == 98)  chk("bd_cnt15", 66'(bus.o_ber_count), HB ? 66'd15 : 66'd0);
      if (b == 98)  chk("bd_lo",    66'(bus.o_hi_ber), 66'd0);
      if (b == 99)  chk("bd_hi",    66'(bus.o_hi_ber), 66'(HB));
      if (b == 100) chk("bd_new0",  66'(bus.o_ber_count), 66'd0);
      if (b == 101) chk("bd_new1",  66'(bus.o_ber_count), 66'(HB));
    end

    // Reset mid-stream with a block present, then descramble from zero history
    step(1'b0, 1'b1, {rnd64(), 2'b01});
    step(1'b1, 1'b1, {rnd64(), 2'b00});
    chk("mrst_valid", 66'(bus.M_VALID), 66'd0);
    chk("mrst_hi",    66'(bus.o_hi_ber), 66'd0);
    step(1'b0, 1'b1, {64'h1, 2'b01});
    chk("mrst_impulse", bus.M_DATA, {64'h0400_0080_0000_0001, 2'b01});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
